// File: rtl/period_meter.sv
// Pulse-train period meter: reports the spacing between rising edges of an
// asynchronous input in ns, with lock tracking and a loss-of-input timeout.
module period_meter #(
    parameter int unsigned clk_period = 20,
    parameter int unsigned max_period = 1_000_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wave,
    output logic [31:0] period,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);

    localparam int unsigned CW = 32;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t        state;
    logic          s1;
    logic          s2;
    logic          d;
    logic [CW-1:0] cnt;
    logic          rise;
    logic [SW-1:0] sum;
    logic [CW-1:0] sum_sat;
    logic          over;

    // Synchronizer and edge-delay stage run independently of en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= wave;
            s2 <= s1;
            d  <= s2;
        end
    end

    assign rise    = s2 & ~d;
    assign sum     = {1'b0, cnt} + SW'(clk_period);
    assign sum_sat = sum[CW] ? '1 : sum[CW-1:0];
    assign over    = sum > SW'(max_period);

    // Measurement FSM; strobes default low so they last exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            if (!en) begin
                state  <= IDLE;
                cnt    <= '0;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt    <= '0;
                        locked <= 1'b0;
                        state  <= ARM;
                    end
                    ARM: begin
                        if (rise) begin
                            cnt   <= '0;
                            state <= MEASURE;
                        end else begin
                            cnt <= sum_sat;
                        end
                    end
                    MEASURE: begin
                        // An edge arriving on the timeout cycle still counts.
                        if (rise) begin
                            period <= sum_sat;
                            valid  <= 1'b1;
                            locked <= 1'b1;
                            cnt    <= '0;
                        end else if (over) begin
                            period  <= '0;
                            locked  <= 1'b0;
                            timeout <= 1'b1;
                            cnt     <= '0;
                            state   <= ARM;
                        end else begin
                            cnt <= sum_sat;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: expected strobes are queued when pulses are
// driven and matched (value and cycle) when valid/timeout appear.
module tb_period_meter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        wave;
    logic [31:0] period;
    logic        valid;
    logic        locked;
    logic        timeout;

    typedef struct {
        int          cyc;
        logic        v;
        logic [31:0] p;
        logic        lk;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    period_meter #(
        .clk_period(20),
        .max_period(1000)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .wave   (wave),
        .period (period),
        .valid  (valid),
        .locked (locked),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse, next pulse 'gap' cycles later; queues a valid if expected.
    task automatic pulse(input int gap, input bit exp_v, input logic [31:0] exp_p);
        exp_t e;
        wave = 1'b1;
        if (exp_v) begin
            e.cyc = cyc + 3;
            e.v   = 1'b1;
            e.p   = exp_p;
            e.lk  = 1'b1;
            sbq.push_back(e);
        end
        tick(1);
        wave = 1'b0;
        tick(gap - 1);
    endtask

    // Scoreboard side: every strobe must match the head of the queue.
    always @(negedge clk) begin
        if (valid === 1'b1 || timeout === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_strobe_queue", 32'(sbq.size()), 32'd1);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                chk("valid", 32'(valid), 32'(e.v));
                chk("timeout", 32'(timeout), 32'(!e.v));
                chk("period", period, e.p);
                chk("locked", 32'(locked), 32'(e.lk));
            end
        end
    end

    initial begin
        exp_t e;
        int   d0;
        rst_n = 1'b0;
        en    = 1'b0;
        wave  = 1'b0;

        // Reset with wave toggling
        for (int i = 0; i < 3; i++) begin
            tick(1);
            wave = ~wave;
        end
        chk("rst_period", period, 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        wave  = 1'b0;
        rst_n = 1'b1;

        // Disabled: pulses must not produce strobes
        pulse(6, 1'b0, 32'd0);
        pulse(6, 1'b0, 32'd0);
        chk("dis_locked", 32'(locked), 32'd0);

        // Steady train at 6 cycles
        en = 1'b1;
        tick(2);
        pulse(6, 1'b0, 32'd0);
        chk("first_edge_unlocked", 32'(locked), 32'd0);
        for (int i = 0; i < 4; i++) pulse(6, 1'b1, 32'd120);
        chk("steady_locked", 32'(locked), 32'd1);
        chk("steady_period", period, 32'd120);

        // Period change 6 -> 11 -> 6
        pulse(11, 1'b1, 32'd120);
        pulse(11, 1'b1, 32'd220);
        pulse(11, 1'b1, 32'd220);
        pulse(6, 1'b1, 32'd220);
        pulse(6, 1'b1, 32'd120);

        // Timeout after the last edge
        d0   = cyc;
        wave = 1'b1;
        e.cyc = d0 + 3;  e.v = 1'b1; e.p = 32'd120; e.lk = 1'b1;
        sbq.push_back(e);
        tick(1);
        wave = 1'b0;
        e.cyc = d0 + 54; e.v = 1'b0; e.p = 32'd0;   e.lk = 1'b0;
        sbq.push_back(e);
        tick(60);
        chk("to_locked", 32'(locked), 32'd0);
        chk("to_period", period, 32'd0);
        chk("to_queue_drained", 32'(sbq.size()), 32'd0);

        // Re-lock after timeout
        pulse(6, 1'b0, 32'd0);
        pulse(6, 1'b1, 32'd120);

        // Enable drop 3 cycles after an edge, wave high across re-enable
        pulse(3, 1'b1, 32'd120);
        en = 1'b0;
        tick(1);
        wave = 1'b1;
        tick(3);
        chk("drop_locked", 32'(locked), 32'd0);
        chk("drop_period", period, 32'd120);
        en = 1'b1;
        tick(3);
        wave = 1'b0;
        tick(2);
        chk("reen_period_hold", period, 32'd120);
        pulse(6, 1'b0, 32'd0);
        pulse(6, 1'b1, 32'd120);

        // Edge lands on the timeout cycle
        en = 1'b0;
        tick(2);
        en = 1'b1;
        tick(3);
        pulse(51, 1'b0, 32'd0);
        pulse(6, 1'b1, 32'd1020);
        chk("coll_locked", 32'(locked), 32'd1);
        chk("coll_period", period, 32'd1020);

        // Reset with an edge in flight: no strobe, outputs cleared
        wave = 1'b1;
        tick(1);
        wave  = 1'b0;
        rst_n = 1'b0;
        tick(2);
        chk("midrst_period", period, 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
        rst_n = 1'b1;
        tick(6);
        en = 1'b0;
        tick(6);

        chk("final_queue_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of an incoming pulse train and reports it in nanoseconds, using the same units and `clk_period` convention as the tone/wave generators. It sits on the input side of the audio path, driven by a wave/pulse source such as a generator output, and feeds the measured period to downstream pitch/display logic. A measurement is reported once per rising edge of the input. Loss of the input is flagged by a timeout.

## Interface
- `clk_period`, default 20: clock period in ns, added to the counter each cycle.
- `max_period`, default 1_000_000_000: timeout threshold in ns; must be ≥ 2·`clk_period`.
- `clk` input, 1 bit: system clock; all logic on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `en` input, 1 bit: measurement enable.
- `wave` input, 1 bit: asynchronous pulse train to measure.
- `period` output, 32 bits: last measured period in ns.
- `valid` output, 1 bit: one-cycle strobe when `period` is updated.
- `locked` output, 1 bit: high while consecutive edges keep arriving within `max_period`.
- `timeout` output, 1 bit: one-cycle strobe when lock is lost.

## Operation
- **Input conditioning.** `wave` goes through a 2-FF synchronizer (`s1`, `s2`) and a delay FF `d`.
  - `rise = s2 & ~d`.
  - The synchronizer and `d` run regardless of `en`.
  - A level that is already high when `en` rises is not an edge.
- **Counter.** `cnt` is 32 bits and unsigned. It adds `clk_period` each cycle in ARM/MEASURE and saturates at 2^32−1 (no wrap).
- **States.**
  - IDLE:
    - Entered when `en`=0.
    - `cnt`←0, `locked`←0, `valid`/`timeout`←0; `period` holds its value.
    - If `en`=1, go to ARM next cycle.
  - ARM (waiting for the first edge):
    - On `rise`: `cnt`←0, go to MEASURE; no `valid`.
  - MEASURE:
    - On `rise`: `period`←`cnt`+`clk_period`, `valid`←1, `locked`←1, `cnt`←0; stay in MEASURE.
    - Else if `cnt`+`clk_period` > `max_period`: `period`←0, `locked`←0, `timeout`←1 for one cycle, `cnt`←0, go to ARM.
    - Else `cnt`←`cnt`+`clk_period`.
- **Arithmetic.** Edges N cycles apart (rise asserted at cycles t0 and t0+N) yield `period` = N·`clk_period`. Comparisons use 33-bit sums so there is no overflow.
- **Priority.**
  - `en`=0 overrides everything: from any state, go to IDLE next cycle and drop any pending capture.
  - `rise` and timeout in the same cycle: `rise` wins.
- **Reset** (`rst_n`=0 at a clock edge):
  - state IDLE; `s1`, `s2`, `d`, `cnt` ← 0.
  - `period`=0, `valid`=0, `locked`=0, `timeout`=0.
  - Applies mid-measurement with no residual strobe.

## Timing
- **Edge latency.** `wave` first sampled high at clock edge E0 gives `rise` combinationally between E1 and E2. `period`/`valid`/`locked` update at E2, so they are visible 2 cycles after the sampling edge.
- **Strobe width.** `valid` and `timeout` are exactly one cycle wide and never asserted together.
- **Hold.** `period` is stable between strobes and holds through IDLE.
- **Minimum period.** Minimum measurable period is 2·`clk_period`. Input high and low phases must each last at least 1 cycle.
- **Timeout.** Timeout fires at the cycle N after the last edge where (N−1)·`clk_period`+`clk_period` > `max_period`. With `clk_period`=20 and `max_period`=1000 this is N=51.
- **Re-enable.** After `en` rises, the first `valid` requires two rising edges, the first of which must arrive at least 1 cycle after entering ARM.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles with `wave` toggling → all outputs 0; after release with `en`=0, `valid` never asserts.
- **Steady train.** `en`=1, 1-cycle pulses every 6 cycles (generator with `period`=100, `clk_period`=20):
  - first edge → no `valid`;
  - second edge → `valid` one cycle, `period`=120, `locked`=1;
  - every later edge → `valid` again with `period`=120.
- **Period change.** Switch the pulse spacing from 6 to 11 cycles → the first `valid` after the switch reports 220, with no intermediate value.
- **Timeout** (`max_period`=1000). Lock at 120, then stop pulses → `timeout` one cycle at 51 cycles after the last `rise`, `locked`=0, `period`=0, no `valid`. The next two edges 6 cycles apart re-lock at 120.
- **Enable drop.** Drop `en` mid-interval (3 cycles after an edge) for 4 cycles, then re-assert → no `valid` or `timeout` during the drop, `locked`=0, `period` still 120. A `wave` already high at re-enable is not counted; the first report comes on the second subsequent edge.
- **Edge/timeout collision** (`max_period`=1000). Place the second edge exactly 51 cycles after the first → `valid` with `period`=1020, `locked`=1, no `timeout`.
